// File: rtl/serial_lsb_first_comparator_pkg.sv
// Shared encodings for the bit-serial LSB-first comparator: FSM states and
// flag-vector bit positions. The testbench imports these too.
package serial_lsb_first_comparator_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int LT = 2;
  localparam int EQ = 1;
  localparam int GT = 0;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_e;

  typedef logic [2:0] flags_t;

  localparam flags_t FLAGS_EQ = 3'b010;

endpackage

// File: rtl/serial_lsb_first_comparator_if.sv
// Load and result handshakes of the serial comparator.
interface serial_lsb_first_comparator_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             out_valid;
  logic             out_ready;
  logic             out_less;
  logic             out_equal;
  logic             out_more;
  logic             busy;

  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, out_less, out_equal, out_more, busy
  );

  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, out_less, out_equal, out_more, busy
  );
endinterface

// File: rtl/lsb_first_compare_step.sv
// One LSB-first compare step: an unequal bit pair overrides whatever the
// lower bits decided; equal bits leave the running flags untouched.
module lsb_first_compare_step (
  input  logic a_bit,
  input  logic b_bit,
  input  logic lt_in,
  input  logic eq_in,
  input  logic gt_in,
  output logic lt_out,
  output logic eq_out,
  output logic gt_out
);
  always_comb begin
    lt_out = lt_in;
    eq_out = eq_in;
    gt_out = gt_in;
    if (a_bit && !b_bit) begin
      lt_out = 1'b0;
      eq_out = 1'b0;
      gt_out = 1'b1;
    end else if (!a_bit && b_bit) begin
      lt_out = 1'b1;
      eq_out = 1'b0;
      gt_out = 1'b0;
    end
  end
endmodule

// File: rtl/serial_lsb_first_comparator.sv
// Bit-serial unsigned magnitude comparator, one bit per clock LSB first.
// Result lands WIDTH cycles after accept and is held until drained.
module serial_lsb_first_comparator
  import serial_lsb_first_comparator_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic clk,
  input  logic reset,
  serial_lsb_first_comparator_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_e           state;
  logic [WIDTH-1:0] a_sh, b_sh;
  logic [CW-1:0]    cnt;
  flags_t           flags, nxt, res;

  lsb_first_compare_step u_step (
    .a_bit  (a_sh[0]),
    .b_bit  (b_sh[0]),
    .lt_in  (flags[LT]),
    .eq_in  (flags[EQ]),
    .gt_in  (flags[GT]),
    .lt_out (nxt[LT]),
    .eq_out (nxt[EQ]),
    .gt_out (nxt[GT])
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      a_sh  <= '0;
      b_sh  <= '0;
      cnt   <= '0;
      flags <= '0;
      res   <= '0;
    end else begin
      case (state)
        S_IDLE: if (bus.in_valid) begin
          a_sh  <= bus.a;
          b_sh  <= bus.b;
          cnt   <= '0;
          flags <= FLAGS_EQ;
          state <= S_RUN;
        end
        S_RUN: begin
          flags <= nxt;
          a_sh  <= a_sh >> 1;
          b_sh  <= b_sh >> 1;
          cnt   <= cnt + 1'b1;
          // Last bit: publish the step output directly, not the stale flags.
          if (cnt == LAST) begin
            res   <= nxt;
            state <= S_DONE;
          end
        end
        S_DONE: if (bus.out_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.in_ready  = (state == S_IDLE) && !reset;
  assign bus.out_valid = (state == S_DONE);
  assign bus.busy      = (state != S_IDLE);
  assign bus.out_less  = res[LT];
  assign bus.out_equal = res[EQ];
  assign bus.out_more  = res[GT];
endmodule

// File: tb/tb_serial_lsb_first_comparator.sv
// Directed bench for the serial comparator: WIDTH=8 instance plus a WIDTH=1 instance.
module tb_serial_lsb_first_comparator;
  import serial_lsb_first_comparator_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   passes = 0;
  int   checks = 0;
  int   n;

  always #5 clk = ~clk;

  serial_lsb_first_comparator_if #(.WIDTH(8)) b8 ();
  serial_lsb_first_comparator_if #(.WIDTH(1)) b1 ();

  serial_lsb_first_comparator #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .bus(b8));
  serial_lsb_first_comparator #(.WIDTH(1)) dut1 (.clk(clk), .reset(reset), .bus(b1));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // {less,equal,more}
  function automatic logic [2:0] res8();
    return {b8.out_less, b8.out_equal, b8.out_more};
  endfunction

  // Counts edges after an accept until out_valid, bounded at 20.
  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!b8.out_valid && cyc < 20) begin
      tick();
      cyc++;
    end
  endtask

  // Single job on the 8-bit instance with out_ready already high.
  task automatic job8(input string tag, input logic [7:0] a, input logic [7:0] b,
                      input logic [2:0] exp);
    int c;
    b8.a = a; b8.b = b; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    wait_valid(c);
    chk({tag, "_lat"}, c, 8);
    chk({tag, "_res"}, res8(), exp);
    tick();
    chk({tag, "_drain"}, {b8.out_valid, b8.in_ready}, 2'b01);
  endtask

  initial begin
    reset = 1'b1;
    b8.in_valid = 1'b0; b8.a = '0; b8.b = '0; b8.out_ready = 1'b0;
    b1.in_valid = 1'b0; b1.a = '0; b1.b = '0; b1.out_ready = 1'b0;
    tick(); tick();
    chk("rst_outs", {b8.out_valid, res8(), b8.busy}, 5'b0);
    chk("rst_in_ready", b8.in_ready, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_rel_in_ready", b8.in_ready, 1'b1);

    // 1: equal, immediate drain, with one-cycle valid
    b8.a = 8'hA5; b8.b = 8'hA5; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    chk("t1_busy", {b8.busy, b8.in_ready, b8.out_valid}, 3'b100);
    wait_valid(n);
    chk("t1_lat", n, 8);
    chk("t1_res", res8(), 3'b010);
    tick();
    chk("t1_onecycle", {b8.out_valid, b8.in_ready}, 2'b01);

    // 2/3: MSB override and LSB-only differences
    job8("t2_msb", 8'h80, 8'h7F, 3'b001);
    job8("t3_lsb", 8'h01, 8'h00, 3'b001);
    job8("t3_less", 8'h00, 8'hFF, 3'b100);
    job8("t3_zero", 8'h00, 8'h00, 3'b010);

    // 4: backpressure, ignored in_valid while busy
    b8.a = 8'h10; b8.b = 8'h20; b8.in_valid = 1'b1; b8.out_ready = 1'b0;
    tick();
    b8.in_valid = 1'b0;
    wait_valid(n);
    chk("t4_lat", n, 8);
    b8.a = 8'hFF; b8.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("t4_hold", {b8.out_valid, res8(), b8.in_ready}, 5'b1_100_0);
    end
    b8.in_valid = 1'b0; b8.out_ready = 1'b1;
    tick();
    chk("t4_drain", {b8.out_valid, b8.in_ready, b8.busy}, 3'b010);
    tick();
    chk("t4_no_ghost", b8.busy, 1'b0);

    // 5: reset at the 4th RUN edge discards the job
    b8.a = 8'hFF; b8.b = 8'h00; b8.in_valid = 1'b1;
    tick();
    b8.in_valid = 1'b0;
    tick(); tick(); tick();
    reset = 1'b1;
    tick();
    chk("t5_rst", {b8.out_valid, res8(), b8.busy, b8.in_ready}, 6'b0);
    reset = 1'b0;
    #1;
    chk("t5_ready", b8.in_ready, 1'b1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (b8.out_valid) n++;
    end
    chk("t5_no_result", n, 0);
    job8("t5_next", 8'h03, 8'h03, 3'b010);

    // 6: back-to-back with in_valid held high
    b8.a = 8'h05; b8.b = 8'h03; b8.in_valid = 1'b1; b8.out_ready = 1'b1;
    tick();
    b8.a = 8'h02; b8.b = 8'h09;
    wait_valid(n);
    chk("t6_lat1", n, 8);
    chk("t6_res1", res8(), 3'b001);
    tick();
    chk("t6_gap", {b8.busy, b8.in_ready, b8.out_valid}, 3'b010);
    tick();
    chk("t6_accept2", {b8.busy, b8.in_ready}, 2'b10);
    b8.in_valid = 1'b0;
    wait_valid(n);
    chk("t6_lat2", n, 8);
    chk("t6_res2", res8(), 3'b100);
    tick();

    // 6b: WIDTH=1 instance
    b1.a = 1'b1; b1.b = 1'b0; b1.in_valid = 1'b1; b1.out_ready = 1'b0;
    tick();
    b1.in_valid = 1'b0;
    chk("w1_run", {b1.busy, b1.out_valid}, 2'b10);
    tick();
    chk("w1_valid", {b1.out_valid, b1.out_less, b1.out_equal, b1.out_more}, 4'b1001);
    b1.out_ready = 1'b1;
    tick();
    chk("w1_drain", {b1.out_valid, b1.in_ready}, 2'b01);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
